// File: rtl/program_sequencer.sv
// program_sequencer
//   Instruction-issue controller for the 9-bit multicycle CPU and its
//   32-word synchronous instruction RAM. It owns the program counter and
//   hands each fetched word to the CPU with a one-cycle Run pulse. It then
//   waits for Done before advancing, and stops on a halt opcode, an
//   unsupported opcode or a Done timeout.
//
//   Optional feature: define SEQ_SINGLE_STEP_EN to add the Step input and
//   the PAUSE state. Each completed instruction then waits for a Step pulse.
//
// Parameters
//   ADDR_BITS  program counter / RAM address width
//   HALT_OP    opcode in IR[8:6] that stops the sequencer
//   TIMEOUT    maximum WAIT cycles allowed before Done is seen
//
// Ports
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-high reset
//   Step        in   single-step advance pulse (SEQ_SINGLE_STEP_EN only)
//   Start       in   begin / resume execution (IDLE, HALT)
//   Done        in   CPU instruction-complete strobe
//   DATAOUT     in   registered RAM read data (also the CPU DIN)
//   ADDRESS     out  RAM read address (decoded from registered state)
//   Run         out  one-cycle issue pulse to the CPU
//   Busy        out  high in FETCH, ISSUE, WAIT (and PAUSE)
//   Halted      out  high in HALT
//   Error       out  sticky fault flag
//   PC          out  program counter
//   InstrCount  out  completed-instruction count, wraps at 255
module program_sequencer #(
  parameter int unsigned ADDR_BITS = 5,
  parameter logic [2:0]  HALT_OP   = 3'b111,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 Step,
`endif
  input  logic                 Start,
  input  logic                 Done,
  input  logic [8:0]           DATAOUT,
  output logic [ADDR_BITS-1:0] ADDRESS,
  output logic                 Run,
  output logic                 Busy,
  output logic                 Halted,
  output logic                 Error,
  output logic [ADDR_BITS-1:0] PC,
  output logic [7:0]           InstrCount
);

  localparam int unsigned TIMER_BITS   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [2:0] OP_MVI = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_BITS-1:0]  pc;
  logic [7:0]            instr_count;
  logic                  busy;
  logic                  halted;
  logic                  error;
  logic [TIMER_BITS-1:0] timer;
  logic [2:0]            op_q;

  logic [2:0] op_c;
  logic       op_halt_c;
  logic       op_illegal_c;
  logic       run_c;

  // Opcode decode of the word the RAM presents during ISSUE.
  assign op_c         = DATAOUT[8:6];
  assign op_halt_c    = (op_c == HALT_OP);
  assign op_illegal_c = (op_c inside {3'b100, 3'b101, 3'b110});

  // Operand fields belong to the CPU; the sequencer only looks at the opcode.
  logic unused_operands;
  assign unused_operands = ^DATAOUT[5:0];

  // Run must be decided in the same cycle the fetched word appears on the
  // registered RAM output, so it is a decode of state and DATAOUT.
  assign run_c = (state == S_ISSUE) && !op_halt_c && !op_illegal_c;

  // In ISSUE/WAIT the RAM is pointed at PC+1 so an mvi immediate lands on
  // DIN during the CPU's T1 cycle.
  always_comb begin
    ADDRESS = pc;
    if (state == S_ISSUE || state == S_WAIT) begin
      ADDRESS = pc + ADDR_BITS'(1);
    end
  end

  // Sequencer state machine with registered status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_count <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      timer       <= '0;
      op_q        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          state <= S_ISSUE;
        end

        S_ISSUE: begin
          if (op_halt_c) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (op_illegal_c) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            error  <= 1'b1;
          end else begin
            state <= S_WAIT;
            op_q  <= op_c;
            timer <= '0;
          end
        end

        S_WAIT: begin
          if (Done) begin
            // mvi consumes its immediate word as well.
            pc          <= pc + ((op_q == OP_MVI) ? ADDR_BITS'(2) : ADDR_BITS'(1));
            instr_count <= instr_count + 8'd1;
`ifdef SEQ_SINGLE_STEP_EN
            state       <= S_PAUSE;
`else
            state       <= S_FETCH;
`endif
          end else if (timer == TIMER_BITS'(TIMEOUT_LAST)) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
            error  <= 1'b1;
          end else begin
            timer <= timer + TIMER_BITS'(1);
          end
        end

        S_HALT: begin
          // Restart always runs the program from the top.
          if (Start) begin
            state  <= S_FETCH;
            pc     <= '0;
            error  <= 1'b0;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end

`ifdef SEQ_SINGLE_STEP_EN
        S_PAUSE: begin
          if (Step) begin
            state <= S_FETCH;
          end
        end
`endif

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

  assign Run        = run_c;
  assign Busy       = busy;
  assign Halted     = halted;
  assign Error      = error;
  assign PC         = pc;
  assign InstrCount = instr_count;

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
//   Directed bench for program_sequencer. It provides a synchronous 32-word
//   instruction RAM and a small multicycle CPU model. The CPU model raises
//   Done in T1 for mv/mvi and in T3 for add/sub.
module tb_program_sequencer;

  localparam int unsigned AW = 5;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Done;
  logic [8:0]    DATAOUT;
  logic [AW-1:0] ADDRESS;
  logic          Run;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [AW-1:0] PC;
  logic [7:0]    InstrCount;
`ifdef SEQ_SINGLE_STEP_EN
  logic          Step = 1'b0;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  program_sequencer #(
    .ADDR_BITS(AW),
    .HALT_OP  (3'b111),
    .TIMEOUT  (4)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
`ifdef SEQ_SINGLE_STEP_EN
    .Step      (Step),
`endif
    .Start     (Start),
    .Done      (Done),
    .DATAOUT   (DATAOUT),
    .ADDRESS   (ADDRESS),
    .Run       (Run),
    .Busy      (Busy),
    .Halted    (Halted),
    .Error     (Error),
    .PC        (PC),
    .InstrCount(InstrCount)
  );

  // Synchronous instruction RAM.
  logic [8:0] mem [32];
  always @(posedge Clock) DATAOUT <= mem[ADDRESS];

  // Small CPU model: IR latched on Run, cstep counts T1, T2, ...
  logic [8:0] ir;
  logic [2:0] cstep;
  logic [8:0] r [8];
  logic       force_done_low;
  logic [8:0] cpu_bus;
  logic [2:0] cop;

  assign cop = ir[8:6];

  always_comb begin
    Done = 1'b0;
    if ((cstep == 3'd1 && (cop == 3'b000 || cop == 3'b001)) ||
        (cstep == 3'd3 && (cop == 3'b010 || cop == 3'b011)))
      Done = 1'b1;
    if (force_done_low) Done = 1'b0;
  end

  always_comb begin
    cpu_bus = '0;
    if (cstep == 3'd1 && cop == 3'b001) cpu_bus = DATAOUT;
    if (cstep == 3'd1 && cop == 3'b000) cpu_bus = r[ir[2:0]];
  end

  always @(posedge Clock) begin
    if (Reset) begin
      cstep <= '0;
      ir    <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else if (Run) begin
      ir    <= DATAOUT;
      cstep <= 3'd1;
    end else if (cstep != 3'd0) begin
      if (Done) begin
        case (cop)
          3'b000:  r[ir[5:3]] <= r[ir[2:0]];
          3'b001:  r[ir[5:3]] <= DATAOUT;
          3'b010:  r[ir[5:3]] <= r[ir[5:3]] + r[ir[2:0]];
          3'b011:  r[ir[5:3]] <= r[ir[5:3]] - r[ir[2:0]];
          default: ;
        endcase
        cstep <= '0;
      end else if (cstep == 3'd7) begin
        cstep <= '0;
      end else begin
        cstep <= cstep + 3'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive and sample at the falling edge, away from the active edge.
  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    force_done_low = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    ticks(2);

    // Reset state
    check("rst_run", Run, 0);
    check("rst_busy", Busy, 0);
    check("rst_halted", Halted, 0);
    check("rst_error", Error, 0);
    check("rst_pc", PC, 0);
    check("rst_cnt", InstrCount, 0);
    check("rst_addr", ADDRESS, 0);
    Reset = 1'b0;
    tick();
    check("idle_busy", Busy, 0);

    // mvi R0,#5 ; mv R1,R0 ; halt
    mem[0] = 9'b001_000_000;
    mem[1] = 9'b000_000_101;
    mem[2] = 9'b000_001_000;
    mem[3] = 9'b111_000_000;
    Start = 1'b1; tick(); Start = 1'b0;                 // FETCH
    check("A1_busy", Busy, 1);
    check("A1_run", Run, 0);
    check("A1_addr", ADDRESS, 0);
    tick();                                             // ISSUE mvi
    check("A2_run", Run, 1);
    check("A2_addr", ADDRESS, 1);
    Start = 1'b1; tick(); Start = 1'b0;                 // WAIT, Start ignored
    check("A3_run", Run, 0);
    check("A3_addr", ADDRESS, 1);
    check("A3_pc", PC, 0);
    check("A3_imm_bus", cpu_bus, 5);
    tick();                                             // FETCH
    check("A4_pc", PC, 2);
    check("A4_cnt", InstrCount, 1);
    check("A4_addr", ADDRESS, 2);
    check("A4_busy", Busy, 1);
    tick();                                             // ISSUE mv
    check("A5_run", Run, 1);
    tick();                                             // WAIT / T1
    check("A6_run", Run, 0);
    check("A6_bus", cpu_bus, 5);
    tick();
    check("A7_pc", PC, 3);
    check("A7_cnt", InstrCount, 2);
    tick();                                             // ISSUE halt
    check("A8_run", Run, 0);
    check("A8_halted", Halted, 0);
    tick();                                             // HALT
    check("A9_halted", Halted, 1);
    check("A9_busy", Busy, 0);
    check("A9_error", Error, 0);
    check("A9_pc", PC, 3);
    check("A9_cnt", InstrCount, 2);
    check("A9_r1", r[1], 5);

    // add R0,R1 ; halt
    mem[0] = 9'b010_000_001;
    mem[1] = 9'b111_000_000;
    Start = 1'b1; tick(); Start = 1'b0;
    check("B1_pc", PC, 0);
    check("B1_halted", Halted, 0);
    check("B1_busy", Busy, 1);
    tick();
    check("B2_run", Run, 1);
    tick();
    check("B3_run", Run, 0);
    ticks(2);
    check("B5_pc", PC, 0);
    check("B5_run", Run, 0);
    tick();
    check("B6_pc", PC, 1);
    check("B6_cnt", InstrCount, 3);
    tick();
    check("B7_run", Run, 0);
    tick();
    check("B8_halted", Halted, 1);
    check("B8_error", Error, 0);
    check("B8_r0", r[0], 10);

    // Unsupported opcodes 100, 101, 110
    for (int op = 4; op <= 6; op++) begin
      mem[0] = {3'(op), 6'b0};
      Start = 1'b1; tick(); Start = 1'b0;
      check("C1_pc", PC, 0);
      tick();
      check("C2_run", Run, 0);
      tick();
      check("C3_halted", Halted, 1);
      check("C3_error", Error, 1);
      check("C3_busy", Busy, 0);
    end
    mem[0] = 9'b111_000_000;
    Start = 1'b1; tick(); Start = 1'b0;
    check("C4_error_clr", Error, 0);
    check("C4_pc", PC, 0);
    check("C4_busy", Busy, 1);
    tick();
    check("C5_run", Run, 0);
    tick();
    check("C6_halted", Halted, 1);
    check("C6_error", Error, 0);

    // Done timeout on add
    mem[0] = 9'b010_000_001;
    force_done_low = 1'b1;
    Start = 1'b1; tick(); Start = 1'b0;
    tick();
    check("D2_run", Run, 1);
    ticks(4);                                           // 4th WAIT cycle
    check("D6_halted", Halted, 0);
    check("D6_busy", Busy, 1);
    check("D6_error", Error, 0);
    tick();
    check("D7_halted", Halted, 1);
    check("D7_error", Error, 1);
    check("D7_pc", PC, 0);
    check("D7_cnt", InstrCount, 3);
    force_done_low = 1'b0;

    // PC wrap: mv R2,R2 in 0..30, mvi R0 at 31 with immediate at 0
    for (int i = 0; i < 31; i++) mem[i] = 9'b000_010_010;
    mem[31] = 9'b001_000_000;
    Start = 1'b1; tick(); Start = 1'b0;
    check("E1_pc", PC, 0);
    ticks(90);
    check("E_pc30", PC, 30);
    ticks(3);
    check("E_pc31", PC, 31);
    check("E_addr31", ADDRESS, 31);
    tick();
    check("E_mvi_run", Run, 1);
    check("E_imm_addr", ADDRESS, 0);
    tick();
    check("E_imm_bus", cpu_bus, 9'h012);
    tick();
    check("E_pc_wrap", PC, 1);
    check("E_cnt", InstrCount, 35);

    // Reset during add WAIT, coinciding with Done and Start
    mem[1] = 9'b010_000_001;
    tick();
    check("F_add_run", Run, 1);
    ticks(3);                                           // third WAIT cycle
    check("F_wait_busy", Busy, 1);
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    Reset = 1'b0;
    Start = 1'b0;
    check("F_run", Run, 0);
    check("F_busy", Busy, 0);
    check("F_halted", Halted, 0);
    check("F_error", Error, 0);
    check("F_pc", PC, 0);
    check("F_cnt", InstrCount, 0);
    check("F_addr", ADDRESS, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("F_idle_run", Run, 0);
      check("F_idle_busy", Busy, 0);
    end
    Start = 1'b1; tick(); Start = 1'b0;
    check("F_restart_busy", Busy, 1);
    tick();
    check("F_restart_run", Run, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
